// File: rtl/button_pio_pkg.sv
// Shared types and constants for the button PIO sequencing controller.
// Bus request bundle plus helpers used by the FSM.
package button_pio_pkg;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_RD_EDGE,
    S_RD_DATA,
    S_CLR,
    S_HOLD
  } state_e;

  localparam logic [1:0]  ADDR_DATA = 2'd0;
  localparam logic [1:0]  ADDR_MASK = 2'd2;
  localparam logic [1:0]  ADDR_EDGE = 2'd3;
  localparam logic [31:0] CLR_ALL   = 32'hFFFF_FFFF;

  typedef struct packed {
    logic        cs;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
  } bus_t;

  localparam bus_t BUS_IDLE = '{
    cs:    1'b0,
    we:    1'b0,
    addr:  2'd0,
    wdata: 32'd0
  };

  function automatic bus_t bus_wr(
    input logic [1:0]  a,
    input logic [31:0] d
  );
    bus_t b;
    b.cs    = 1'b1;
    b.we    = 1'b1;
    b.addr  = a;
    b.wdata = d;
    return b;
  endfunction

  function automatic bus_t bus_rd(
    input logic [1:0] a
  );
    bus_t b;
    b.cs    = 1'b1;
    b.we    = 1'b0;
    b.addr  = a;
    b.wdata = 32'd0;
    return b;
  endfunction

endpackage

// File: rtl/button_evt_fifo.sv
// Small event FIFO: push/full on the write side, valid/ready on the read side.
// Depth must be a power of two so the pointers wrap naturally.
module button_evt_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  output logic         full_o,
  output logic         pop_valid_o,
  output logic [W-1:0] pop_data_o,
  input  logic         pop_ready_i
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign pop_valid_o = (cnt_q != '0);
  assign full_o      = (cnt_q == FULL_CNT);
  assign do_pop      = pop_valid_o && pop_ready_i;
  // A full FIFO still accepts a push when the same cycle frees a slot.
  assign do_push     = push_i && (!full_o || do_pop);
  assign pop_data_o  = pop_valid_o ? mem_q[rd_ptr_q] : '0;

  assign cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/button_pio_ctrl.sv
// Button PIO sequencer: programs irq_mask, services edge interrupts,
// clears edge_capture, holds off for debounce and queues events.
module button_pio_ctrl
  import button_pio_pkg::*;
#(
  parameter int DATA_WIDTH     = 4,
  parameter int FIFO_DEPTH     = 4,
  parameter logic [DATA_WIDTH-1:0] INIT_MASK = DATA_WIDTH'(4'hF),
  parameter int HOLDOFF_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  output logic [1:0]            pio_address,
  output logic                  pio_chipselect,
  output logic                  pio_write_n,
  output logic [31:0]           pio_writedata,
  input  logic [31:0]           pio_readdata,
  input  logic                  pio_irq,
  input  logic                  cfg_valid,
  input  logic [DATA_WIDTH-1:0] cfg_mask,
  output logic                  cfg_ready,
  output logic                  evt_valid,
  output logic [DATA_WIDTH-1:0] evt_edges,
  output logic [DATA_WIDTH-1:0] evt_level,
  input  logic                  evt_ready
);

  localparam int DW = DATA_WIDTH;
  localparam int CW = $clog2(HOLDOFF_CYCLES + 1);

  state_e          state_q, state_d;
  bus_t            bus_q, bus_d;
  logic            cfg_ready_q, cfg_ready_d;
  logic [CW-1:0]   hold_q, hold_d;
  logic [DW-1:0]   edges_q, edges_d;
  logic            push, full;
  logic [2*DW-1:0] push_data, pop_data;
  logic            unused_rd;

  assign unused_rd = ^pio_readdata[31:DW];
  assign push_data = {edges_q, pio_readdata[DW-1:0]};

  // Bus request is registered: it is chosen on the transition
  // into the state that owns the access.
  always_comb begin
    state_d     = state_q;
    bus_d       = BUS_IDLE;
    cfg_ready_d = 1'b0;
    hold_d      = hold_q;
    edges_d     = edges_q;
    push        = 1'b0;
    unique case (state_q)
      S_INIT: begin
        state_d = S_IDLE;
        bus_d   = bus_wr(ADDR_MASK, 32'(INIT_MASK));
      end
      S_IDLE: begin
        if (cfg_valid && !cfg_ready_q) begin
          bus_d       = bus_wr(ADDR_MASK, 32'(cfg_mask));
          cfg_ready_d = 1'b1;
        end else if (pio_irq && !full) begin
          state_d = S_RD_EDGE;
          bus_d   = bus_rd(ADDR_EDGE);
        end
      end
      S_RD_EDGE: begin
        state_d = S_RD_DATA;
        bus_d   = bus_rd(ADDR_DATA);
      end
      S_RD_DATA: begin
        state_d = S_CLR;
        edges_d = pio_readdata[DW-1:0];
        bus_d   = bus_wr(ADDR_EDGE, CLR_ALL);
      end
      S_CLR: begin
        state_d = S_HOLD;
        hold_d  = CW'(HOLDOFF_CYCLES);
        push    = |edges_q;
      end
      S_HOLD: begin
        hold_d = hold_q - CW'(1);
        if (hold_q <= CW'(1)) state_d = S_IDLE;
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_INIT;
      bus_q       <= BUS_IDLE;
      cfg_ready_q <= 1'b0;
      hold_q      <= '0;
      edges_q     <= '0;
    end else begin
      state_q     <= state_d;
      bus_q       <= bus_d;
      cfg_ready_q <= cfg_ready_d;
      hold_q      <= hold_d;
      edges_q     <= edges_d;
    end
  end

  assign pio_chipselect = bus_q.cs;
  assign pio_write_n    = ~bus_q.we;
  assign pio_address    = bus_q.addr;
  assign pio_writedata  = bus_q.wdata;
  assign cfg_ready      = cfg_ready_q;

  button_evt_fifo #(
    .W     (2 * DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (reset_n),
    .push_i      (push),
    .push_data_i (push_data),
    .full_o      (full),
    .pop_valid_o (evt_valid),
    .pop_data_o  (pop_data),
    .pop_ready_i (evt_ready)
  );

  assign evt_edges = pop_data[2*DW-1:DW];
  assign evt_level = pop_data[DW-1:0];

endmodule

// File: tb/tb_button_pio_ctrl.sv
// Bench for button_pio_ctrl with a behavioural 4-bit button PIO.
// Bus accesses and events are checked against queued expectations.
module tb_button_pio_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  pio_address;
  logic        pio_chipselect;
  logic        pio_write_n;
  logic [31:0] pio_writedata;
  logic [31:0] pio_readdata;
  logic        pio_irq;
  logic        cfg_valid = 1'b0;
  logic [3:0]  cfg_mask = 4'h0;
  logic        cfg_ready;
  logic        evt_valid;
  logic [3:0]  evt_edges;
  logic [3:0]  evt_level;
  logic        evt_ready = 1'b0;

  int total = 0;
  int bad   = 0;

  logic [34:0] bus_exp [$];
  logic [7:0]  ev_exp  [$];
  logic [34:0] mon_bus;
  logic [7:0]  mon_ev;

  logic [3:0] btn    = 4'h0;
  logic [3:0] btn_d  = 4'h0;
  logic [3:0] ecap   = 4'h0;
  logic [3:0] mask_m = 4'h0;
  logic       spur   = 1'b0;

  always #5 clk = ~clk;

  button_pio_ctrl dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .pio_address    (pio_address),
    .pio_chipselect (pio_chipselect),
    .pio_write_n    (pio_write_n),
    .pio_writedata  (pio_writedata),
    .pio_readdata   (pio_readdata),
    .pio_irq        (pio_irq),
    .cfg_valid      (cfg_valid),
    .cfg_mask       (cfg_mask),
    .cfg_ready      (cfg_ready),
    .evt_valid      (evt_valid),
    .evt_edges      (evt_edges),
    .evt_level      (evt_level),
    .evt_ready      (evt_ready)
  );

  // PIO model: rising-edge capture, write-1-to-clear, registered read.
  always @(posedge clk) begin
    btn_d <= btn;
    case (pio_address)
      2'd0:    pio_readdata <= {28'hABCDEF0, btn};
      2'd2:    pio_readdata <= {28'hABCDEF0, mask_m};
      2'd3:    pio_readdata <= {28'hABCDEF0, ecap};
      default: pio_readdata <= {28'hABCDEF0, 4'h0};
    endcase
    if (pio_chipselect && !pio_write_n && pio_address == 2'd3)
      ecap <= (ecap & ~pio_writedata[3:0]) | (btn & ~btn_d);
    else
      ecap <= ecap | (btn & ~btn_d);
    if (pio_chipselect && !pio_write_n && pio_address == 2'd2)
      mask_m <= pio_writedata[3:0];
  end

  assign pio_irq = (|(ecap & mask_m)) | spur;

  task automatic chk(
    input string       nm,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [34:0] op(
    input logic        w,
    input logic [1:0]  a,
    input logic [31:0] d
  );
    return {w, a, d};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic exp_svc();
    bus_exp.push_back(op(1'b0, 2'd3, 32'h0));
    bus_exp.push_back(op(1'b0, 2'd0, 32'h0));
    bus_exp.push_back(op(1'b1, 2'd3, 32'hFFFF_FFFF));
  endtask

  task automatic drain(input int lim);
    evt_ready = 1'b1;
    for (int i = 0; i < lim && (ev_exp.size() != 0 || evt_valid); i++)
      tick(1);
    chk("drain", {ev_exp.size() != 0, evt_valid}, 0);
    evt_ready = 1'b0;
  endtask

  // Monitor: compares every bus access and every popped event.
  always @(negedge clk) begin
    if (reset_n) begin
      if (pio_chipselect) begin
        mon_bus = {~pio_write_n, pio_address,
                   pio_write_n ? 32'h0 : pio_writedata};
        if (bus_exp.size() == 0)
          chk("bus_extra", {1'b1, mon_bus}, 0);
        else
          chk("bus_op", mon_bus, bus_exp.pop_front());
      end
      if (evt_valid && evt_ready) begin
        mon_ev = {evt_edges, evt_level};
        if (ev_exp.size() == 0)
          chk("evt_extra", {1'b1, mon_ev}, 0);
        else
          chk("evt", mon_ev, ev_exp.pop_front());
      end
    end
  end

  initial begin
    bus_exp.push_back(op(1'b1, 2'd2, 32'hF));
    tick(2);
    chk("rst_cs", pio_chipselect, 0);
    chk("rst_wn", pio_write_n, 1);
    chk("rst_addr", pio_address, 0);
    chk("rst_wdata", pio_writedata, 0);
    chk("rst_cfg_rdy", cfg_ready, 0);
    chk("rst_evt", {evt_valid, evt_edges, evt_level}, 0);
    reset_n = 1'b1;
    tick(1);
    chk("init_wr", {pio_chipselect, pio_write_n, pio_address,
                    pio_writedata[3:0]}, 8'b1_0_10_1111);
    tick(1);
    chk("init_idle", {pio_chipselect, pio_write_n, pio_address}, 4'b0100);
    tick(3);

    // Single press with holdoff gating the next service
    btn = 4'h4;
    exp_svc();
    ev_exp.push_back(8'h44);
    tick(1);
    tick(3);
    chk("evt_pre", evt_valid, 0);
    tick(1);
    chk("evt_rise", evt_valid, 1);
    chk("evt_head", {evt_edges, evt_level}, 8'h44);
    tick(1);
    btn = 4'h5;
    exp_svc();
    ev_exp.push_back(8'h15);
    tick(15);
    chk("hold_quiet", pio_chipselect, 0);
    tick(1);
    chk("svc2_start", {pio_chipselect, pio_write_n, pio_address}, 4'b1111);
    tick(20);
    drain(20);

    // Spurious interrupt: full sequence, nothing queued
    tick(1);
    spur = 1'b1;
    exp_svc();
    tick(1);
    spur = 1'b0;
    tick(4);
    chk("spur_evt_a", evt_valid, 0);
    tick(20);
    chk("spur_evt_b", evt_valid, 0);

    // Fill the FIFO, fifth press must wait for a pop
    btn = 4'h0;
    tick(2);
    for (int k = 0; k < 4; k++) begin
      btn = 4'h1 << k;
      exp_svc();
      ev_exp.push_back({btn, btn});
      tick(24);
      btn = 4'h0;
      tick(2);
    end
    chk("full_valid", evt_valid, 1);
    btn = 4'h3;
    tick(30);
    chk("irq_pend", pio_irq, 1);
    btn = 4'h0;
    exp_svc();
    ev_exp.push_back(8'h30);
    evt_ready = 1'b1;
    tick(1);
    evt_ready = 1'b0;
    tick(25);
    chk("fifth_svc", evt_valid, 1);
    drain(20);

    // Mask rewrite requested during holdoff, racing a new irq
    evt_ready = 1'b1;
    tick(2);
    btn = 4'h8;
    exp_svc();
    ev_exp.push_back(8'h88);
    tick(1);
    tick(6);
    cfg_valid = 1'b1;
    cfg_mask = 4'h3;
    btn = 4'h9;
    bus_exp.push_back(op(1'b1, 2'd2, 32'h3));
    exp_svc();
    ev_exp.push_back(8'h19);
    tick(14);
    chk("cfg_wait", {cfg_ready, pio_chipselect}, 0);
    tick(1);
    chk("cfg_ack", {cfg_ready, pio_chipselect, pio_write_n,
                    pio_address}, 5'b11010);
    tick(1);
    cfg_valid = 1'b0;
    chk("cfg_pulse", cfg_ready, 0);
    chk("irq_after_cfg", {pio_chipselect, pio_write_n, pio_address},
        4'b1111);
    tick(25);
    drain(10);

    // Reset in the middle of a service
    btn = 4'h0;
    tick(2);
    btn = 4'h1;
    exp_svc();
    tick(26);
    chk("pre_rst_valid", evt_valid, 1);
    btn = 4'h0;
    tick(2);
    btn = 4'h2;
    bus_exp.push_back(op(1'b0, 2'd3, 32'h0));
    tick(1);
    tick(2);
    reset_n = 1'b0;
    #1;
    chk("arst_bus", {pio_chipselect, pio_write_n, pio_address,
                     pio_writedata}, {1'b0, 1'b1, 2'd0, 32'h0});
    chk("arst_evt", {evt_valid, evt_edges, evt_level, cfg_ready}, 0);
    tick(2);
    bus_exp.push_back(op(1'b1, 2'd2, 32'hF));
    exp_svc();
    ev_exp.push_back(8'h22);
    reset_n = 1'b1;
    tick(1);
    chk("reinit_wr", {pio_chipselect, pio_write_n, pio_address,
                      pio_writedata[3:0]}, 8'b1_0_10_1111);
    drain(40);
    tick(20);
    chk("bus_left", bus_exp.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/button_pio_ctrl.md
# button_pio_ctrl

Sequencing controller for the 4-bit button PIO slave: on reset release it programs the PIO interrupt mask; thereafter it services the PIO interrupt. Servicing reads edge_capture and the live button level, clears edge_capture, then waits out a debounce holdoff. Serviced events are queued in a small FIFO toward the consumer. It sits between the PIO's Avalon-MM slave port and the application logic, replacing software ISR handling.

## Interface
- DATA_WIDTH, 4, button/PIO bit width
- FIFO_DEPTH, 4, event FIFO entries (power of 2, ≥2)
- INIT_MASK, 4'hF, irq_mask written after reset
- HOLDOFF_CYCLES, 16, debounce holdoff after each clear (≥1, counter width $clog2(HOLDOFF_CYCLES+1))

Ports:
- clk  in  1  single clock
- reset_n  in  1  asynchronous, active-low reset
- pio_address  out  2  PIO register select (0 data, 2 irq_mask, 3 edge_capture)
- pio_chipselect  out  1  PIO access strobe
- pio_write_n  out  1  active-low write
- pio_writedata  out  32  write data
- pio_readdata  in  32  PIO registered read data (valid one cycle after address)
- pio_irq  in  1  PIO interrupt
- cfg_valid  in  1  request to rewrite irq_mask (held until cfg_ready)
- cfg_mask  in  DATA_WIDTH  new mask
- cfg_ready  out  1  one-cycle acknowledge of the mask write
- evt_valid  out  1  FIFO non-empty
- evt_edges  out  DATA_WIDTH  captured edge bits of head event
- evt_level  out  DATA_WIDTH  button level sampled with head event
- evt_ready  in  1  consumer pop

## Operation
- States: INIT, IDLE, RD_EDGE, RD_DATA, CLR, HOLD.
- INIT (one cycle after reset release): write addr 2, writedata = INIT_MASK zero-extended → IDLE.
- IDLE priority: cfg_valid → write addr 2 with cfg_mask, cfg_ready=1 for that cycle, stay IDLE. Otherwise pio_irq && FIFO not full → RD_EDGE. Otherwise hold.
- FIFO full: no servicing. irq stays high and the PIO holds its edges, so no edge is lost.
- RD_EDGE: chipselect=1, write_n=1, address=3 → RD_DATA.
- RD_DATA: address=0 read; capture pio_readdata[DATA_WIDTH-1:0] as edges → CLR.
- CLR: write addr 3, writedata=32'hFFFF_FFFF; capture pio_readdata as level; push {edges, level} only if edges≠0 (spurious irq dropped); → HOLD.
- HOLD: counter loads HOLDOFF_CYCLES at CLR exit, decrements each cycle; at 0 → IDLE. cfg_valid is not honoured outside IDLE.
- FIFO: push and pop in the same cycle when full is legal only if a pop frees the slot. Push is never attempted when full, because fullness is checked in IDLE and only one push happens per service. Simultaneous push and pop keeps occupancy constant. Pointers wrap modulo FIFO_DEPTH.
- Upper readdata bits [31:DATA_WIDTH] are ignored.

## Timing
- Reset values: pio_address=0, pio_chipselect=0, pio_write_n=1, pio_writedata=0, cfg_ready=0, evt_valid=0, evt_edges=0, evt_level=0; state=INIT, FIFO empty, holdoff counter=0.
- All outputs are registered-state decoded. Bus outputs are idle (cs=0, write_n=1, addr=0, wdata=0) in IDLE without cfg, and in HOLD.
- irq sampled high in IDLE at edge T → RD_EDGE at T+1, RD_DATA T+2, CLR T+3. evt_valid rises at T+4 if the FIFO was empty. IDLE is re-entered at T+4+HOLDOFF_CYCLES.
- Next service is possible no earlier than T+5+HOLDOFF_CYCLES.
- Asynchronous reset mid-service aborts immediately; FIFO contents are discarded; INIT reruns (mask rewritten, pending PIO edges serviced afterwards).

## Structure
- Package button_pio_pkg: state enum, PIO address constants (ADDR_DATA=0, ADDR_MASK=2, ADDR_EDGE=3), CLR_ALL=32'hFFFF_FFFF.
- Sub-module button_evt_fifo (parameterised width 2*DATA_WIDTH, depth FIFO_DEPTH, valid/ready pop, push/full). The FSM and holdoff counter live in the top.

## Test plan
- Reset release with PIO model → exactly one write addr 2 data 0xF, then bus idle; all outputs at reset values.
- Press bit 2 (edges=4'b0100, level=4'b0100) → reads addr 3 then addr 0, write addr 3 data 0xFFFFFFFF; event {0100,0100} appears at T+4; next irq not serviced before T+5+16.
- Spurious irq with edge_capture=0 → full read/clear sequence, no event pushed, evt_valid stays 0.
- evt_ready=0, five distinct presses, FIFO_DEPTH=4 → four events queued; fifth irq stays pending with no bus activity. Popping one → fifth is serviced and its edge value is preserved.
- cfg_valid with mask 0x3 asserted during HOLD → write addr 2 data 0x3 occurs in the first IDLE cycle with cfg_ready pulse, taking priority over a simultaneous irq (irq serviced the next cycle).
- reset_n asserted during RD_DATA → outputs return to reset values asynchronously, FIFO empty, INIT mask write after release.
